// File: rtl/router_term_monitor.sv
// -----------------------------------------------------------------------------
// router_term_monitor
//
// Passive checker that watches every output terminal of a ROWS x COLUMS mesh
// router. It flags stalled packets (timeout), misrouted packets (dst), pops
// without a pending packet (proto) and payloads that change while held
// pending (stab). It also counts delivered packets per terminal and captures
// the first error seen since the last reset/clear.
//
// Handshake: pndng[i] is the valid and pop[i] the ready of terminal i. A
// transfer happens in a cycle with pndng[i]=1 and pop[i]=1. A cycle with
// pndng[i]=1 and pop[i]=0 is a wait cycle, and the router must then hold
// data_out[i] stable. pop[i]=1 with pndng[i]=0 is a protocol violation.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   clr            synchronous clear of flags, counters, wait counters, capture
//   data_out       per-terminal packet, terminal i at [i*PCK_SZ +: PCK_SZ]
//   pndng, pop     per-terminal handshake
//   timeout_err    sticky: TIMEOUT consecutive wait cycles
//   dst_err        sticky: transfer whose destination field is not i
//   proto_err      sticky: pop without pndng
//   stab_err       sticky: data changed after a wait cycle while still pending
//   pkt_cnt        saturating delivered-packet counts, terminal i at [i*CNT_W +: CNT_W]
//   err_any        OR of all sticky flags
//   first_err_*    capture of the first error (terminal, code, data)
// -----------------------------------------------------------------------------
module router_term_monitor #(
  parameter int ROWS     = 4,
  parameter int COLUMS   = 4,
  parameter int PCK_SZ   = 40,
  parameter int DST_MSB  = 39,
  parameter int DST_LSB  = 34,
  parameter int TIMEOUT  = 128,
  parameter int CNT_W    = 16,
  parameter int BCAST_EN = 0,
  parameter int BCAST_ID = 63,
  localparam int N_TERMS = 2*ROWS + 2*COLUMS,
  localparam int TERM_W  = $clog2(N_TERMS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic [N_TERMS*PCK_SZ-1:0] data_out,
  input  logic [N_TERMS-1:0]        pndng,
  input  logic [N_TERMS-1:0]        pop,
  output logic [N_TERMS-1:0]        timeout_err,
  output logic [N_TERMS-1:0]        dst_err,
  output logic [N_TERMS-1:0]        proto_err,
  output logic [N_TERMS-1:0]        stab_err,
  output logic [N_TERMS*CNT_W-1:0]  pkt_cnt,
  output logic                      err_any,
  output logic                      first_err_vld,
  output logic [TERM_W-1:0]         first_err_term,
  output logic [1:0]                first_err_code,
  output logic [PCK_SZ-1:0]         first_err_data
);

  localparam int DST_W = DST_MSB - DST_LSB + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CODE_DST   = 2'd0;
  localparam logic [1:0] CODE_TO    = 2'd1;
  localparam logic [1:0] CODE_PROTO = 2'd2;
  localparam logic [1:0] CODE_STAB  = 2'd3;

  // Per-terminal state
  logic [TO_W-1:0]   wcnt_q [N_TERMS];
  logic [TO_W-1:0]   wcnt_d [N_TERMS];
  logic [PCK_SZ-1:0] dreg_q [N_TERMS];
  logic [PCK_SZ-1:0] dreg_d [N_TERMS];
  logic [CNT_W-1:0]  cnt_q  [N_TERMS];
  logic [CNT_W-1:0]  cnt_d  [N_TERMS];
  logic [N_TERMS-1:0] prev_wait_q, prev_wait_d;

  logic [N_TERMS-1:0] to_q, to_d, dst_q, dst_d, proto_q, proto_d, stab_q, stab_d;
  logic               err_any_q, err_any_d;
  logic               fe_vld_q, fe_vld_d;
  logic [TERM_W-1:0]  fe_term_q, fe_term_d;
  logic [1:0]         fe_code_q, fe_code_d;
  logic [PCK_SZ-1:0]  fe_data_q, fe_data_d;

  // Combinational event detection
  logic [PCK_SZ-1:0]  pkt [N_TERMS];
  logic [DST_W-1:0]   fld [N_TERMS];
  logic [N_TERMS-1:0] xfer, wait_c, to_evt, dst_evt, proto_evt, stab_evt;

  always_comb begin
    for (int i = 0; i < N_TERMS; i++) begin
      pkt[i]       = data_out[i*PCK_SZ +: PCK_SZ];
      fld[i]       = pkt[i][DST_MSB:DST_LSB];
      xfer[i]      = pndng[i] & pop[i];
      wait_c[i]    = pndng[i] & ~pop[i];
      // wcnt_q holds the waits already seen, so TIMEOUT-1 marks the TIMEOUT-th.
      to_evt[i]    = wait_c[i] && (wcnt_q[i] == TO_W'(TIMEOUT - 1));
      dst_evt[i]   = xfer[i] && (fld[i] != DST_W'(i)) &&
                     !((BCAST_EN != 0) && (fld[i] == DST_W'(BCAST_ID)));
      proto_evt[i] = pop[i] & ~pndng[i];
      stab_evt[i]  = pndng[i] && prev_wait_q[i] && (pkt[i] != dreg_q[i]);
    end
  end

  // Per-terminal next state
  always_comb begin
    for (int i = 0; i < N_TERMS; i++) begin
      wcnt_d[i] = wcnt_q[i];
      if (clr || !wait_c[i])
        wcnt_d[i] = '0;
      else if (wcnt_q[i] != TO_W'(TIMEOUT))
        wcnt_d[i] = wcnt_q[i] + 1'b1;

      dreg_d[i] = wait_c[i] ? pkt[i] : dreg_q[i];

      cnt_d[i] = cnt_q[i];
      if (clr)
        cnt_d[i] = '0;
      else if (xfer[i] && (cnt_q[i] != {CNT_W{1'b1}}))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
    prev_wait_d = wait_c;

    // An event in the clearing cycle still lands in the flag.
    to_d    = clr ? to_evt    : (to_q    | to_evt);
    dst_d   = clr ? dst_evt   : (dst_q   | dst_evt);
    proto_d = clr ? proto_evt : (proto_q | proto_evt);
    stab_d  = clr ? stab_evt  : (stab_q  | stab_evt);
    err_any_d = |{to_d, dst_d, proto_d, stab_d};
  end

  // First-error selection: lowest terminal, then lowest code.
  logic              found;
  logic [TERM_W-1:0] sel_term;
  logic [1:0]        sel_code;
  logic [PCK_SZ-1:0] sel_data;

  always_comb begin
    found    = 1'b0;
    sel_term = '0;
    sel_code = '0;
    sel_data = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      if (!found && (dst_evt[i] | to_evt[i] | proto_evt[i] | stab_evt[i])) begin
        found    = 1'b1;
        sel_term = TERM_W'(i);
        sel_data = pkt[i];
        if (dst_evt[i])      sel_code = CODE_DST;
        else if (to_evt[i])  sel_code = CODE_TO;
        else if (proto_evt[i]) sel_code = CODE_PROTO;
        else                 sel_code = CODE_STAB;
      end
    end

    fe_vld_d  = fe_vld_q;
    fe_term_d = fe_term_q;
    fe_code_d = fe_code_q;
    fe_data_d = fe_data_q;
    if (clr || (!fe_vld_q && found)) begin
      fe_vld_d  = found;
      fe_term_d = sel_term;
      fe_code_d = sel_code;
      fe_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_TERMS; i++) begin
        wcnt_q[i] <= '0;
        dreg_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      prev_wait_q <= '0;
      to_q        <= '0;
      dst_q       <= '0;
      proto_q     <= '0;
      stab_q      <= '0;
      err_any_q   <= 1'b0;
      fe_vld_q    <= 1'b0;
      fe_term_q   <= '0;
      fe_code_q   <= '0;
      fe_data_q   <= '0;
    end else begin
      for (int i = 0; i < N_TERMS; i++) begin
        wcnt_q[i] <= wcnt_d[i];
        dreg_q[i] <= dreg_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      prev_wait_q <= prev_wait_d;
      to_q        <= to_d;
      dst_q       <= dst_d;
      proto_q     <= proto_d;
      stab_q      <= stab_d;
      err_any_q   <= err_any_d;
      fe_vld_q    <= fe_vld_d;
      fe_term_q   <= fe_term_d;
      fe_code_q   <= fe_code_d;
      fe_data_q   <= fe_data_d;
    end
  end

  assign timeout_err    = to_q;
  assign dst_err        = dst_q;
  assign proto_err      = proto_q;
  assign stab_err       = stab_q;
  assign err_any        = err_any_q;
  assign first_err_vld  = fe_vld_q;
  assign first_err_term = fe_term_q;
  assign first_err_code = fe_code_q;
  assign first_err_data = fe_data_q;

  for (genvar g = 0; g < N_TERMS; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_router_term_monitor.sv
module tb_router_term_monitor;
  localparam int N  = 16;
  localparam int PW = 40;
  localparam int CW = 16;
  localparam int W  = 64;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic [N*PW-1:0] data_out = '0;
  logic [N-1:0]    pndng = '0;
  logic [N-1:0]    pop = '0;

  logic [N-1:0]    timeout_err, dst_err, proto_err, stab_err;
  logic [N*CW-1:0] pkt_cnt;
  logic            err_any, first_err_vld;
  logic [3:0]      first_err_term;
  logic [1:0]      first_err_code;
  logic [PW-1:0]   first_err_data;

  logic [N-1:0]    b_timeout_err, b_dst_err, b_proto_err, b_stab_err;
  logic [N*CW-1:0] b_pkt_cnt;
  logic            b_err_any, b_first_err_vld;
  logic [3:0]      b_first_err_term;
  logic [1:0]      b_first_err_code;
  logic [PW-1:0]   b_first_err_data;

  router_term_monitor dut (
    .clk(clk), .reset(reset), .clr(clr), .data_out(data_out), .pndng(pndng), .pop(pop),
    .timeout_err(timeout_err), .dst_err(dst_err), .proto_err(proto_err), .stab_err(stab_err),
    .pkt_cnt(pkt_cnt), .err_any(err_any), .first_err_vld(first_err_vld),
    .first_err_term(first_err_term), .first_err_code(first_err_code),
    .first_err_data(first_err_data)
  );

  router_term_monitor #(.BCAST_EN(1)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .data_out(data_out), .pndng(pndng), .pop(pop),
    .timeout_err(b_timeout_err), .dst_err(b_dst_err), .proto_err(b_proto_err),
    .stab_err(b_stab_err), .pkt_cnt(b_pkt_cnt), .err_any(b_err_any),
    .first_err_vld(b_first_err_vld), .first_err_term(b_first_err_term),
    .first_err_code(b_first_err_code), .first_err_data(b_first_err_data)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp;
  int vectors = 0;
  int miscompares = 0;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    pndng = '0;
    pop   = '0;
    clr   = 1'b1;
    step();
    clr   = 1'b0;
  endtask

  function automatic logic [PW-1:0] mk_pkt(input int dst);
    logic [PW-1:0] p;
    logic [31:0] d;
    d = dst;
    p = PW'({$urandom(), $urandom()});
    p[39:34] = d[5:0];
    return p;
  endfunction

  task automatic set_pkt(input int t, input logic [PW-1:0] p);
    data_out[t*PW +: PW] = p;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int t);
    return pkt_cnt[t*CW +: CW];
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    #3;
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp = exp_q.pop_front();
    vectors++;
    if ({timeout_err, dst_err, proto_err, stab_err} !== exp[W-1:0]) begin
      miscompares++;
      $display("FAIL reset_flags: got %h want %h", {timeout_err, dst_err, proto_err, stab_err}, exp);
    end
    exp = exp_q.pop_front();
    vectors++;
    if ({err_any, first_err_vld, |pkt_cnt, first_err_data} !== exp[42:0]) begin
      miscompares++;
      $display("FAIL reset_misc: got %h want %h", {err_any, first_err_vld, |pkt_cnt, first_err_data}, exp[42:0]);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_timeout();
    logic [PW-1:0] p;
    p = mk_pkt(3);
    set_pkt(3, p);
    pndng[3] = 1'b1;
    exp_q.push_back('0);
    repeat (127) step();
    exp = exp_q.pop_front();
    vectors++;
    if (timeout_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL timeout_127: got %h want %h", timeout_err, exp[N-1:0]);
    end
    exp_q.push_back(64'(1) << 3);
    step();
    exp = exp_q.pop_front();
    vectors++;
    if (timeout_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL timeout_128: got %h want %h", timeout_err, exp[N-1:0]);
    end
    vectors++;
    if ({first_err_vld, first_err_term, first_err_code, first_err_data} !== {1'b1, 4'd3, 2'd1, p}) begin
      miscompares++;
      $display("FAIL timeout_capture: got %h want %h", {first_err_vld, first_err_term, first_err_code, first_err_data}, {1'b1, 4'd3, 2'd1, p});
    end
    do_clr();
    vectors++;
    if ({timeout_err, err_any, first_err_vld} !== '0) begin
      miscompares++;
      $display("FAIL timeout_clr: got %h want 0", {timeout_err, err_any, first_err_vld});
    end
    // pop lands on the 128th cycle: no timeout
    pndng[3] = 1'b1;
    repeat (127) step();
    pop[3] = 1'b1;
    exp_q.push_back('0);
    step();
    pop[3] = 1'b0;
    pndng[3] = 1'b0;
    exp = exp_q.pop_front();
    vectors++;
    if (timeout_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL timeout_pop128: got %h want %h", timeout_err, exp[N-1:0]);
    end
    vectors++;
    if (cnt_of(3) !== 16'd1) begin
      miscompares++;
      $display("FAIL timeout_pop128_cnt: got %0d want 1", cnt_of(3));
    end
    do_clr();
  endtask

  task automatic test_dst();
    logic [PW-1:0] p;
    p = mk_pkt(7);
    set_pkt(5, p);
    pndng[5] = 1'b1;
    pop[5] = 1'b1;
    exp_q.push_back(64'(1) << 5);
    step();
    pndng = '0;
    pop = '0;
    exp = exp_q.pop_front();
    vectors++;
    if (dst_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL dst_bad: got %h want %h", dst_err, exp[N-1:0]);
    end
    vectors++;
    if ({first_err_vld, first_err_term, first_err_code, first_err_data, cnt_of(5)} !== {1'b1, 4'd5, 2'd0, p, 16'd1}) begin
      miscompares++;
      $display("FAIL dst_capture: got %h want %h", {first_err_vld, first_err_term, first_err_code, first_err_data, cnt_of(5)}, {1'b1, 4'd5, 2'd0, p, 16'd1});
    end
    do_clr();
    p = mk_pkt(5);
    set_pkt(5, p);
    pndng[5] = 1'b1;
    pop[5] = 1'b1;
    exp_q.push_back('0);
    step();
    pndng = '0;
    pop = '0;
    exp = exp_q.pop_front();
    vectors++;
    if ({dst_err, err_any} !== exp[N:0]) begin
      miscompares++;
      $display("FAIL dst_good: got %h want %h", {dst_err, err_any}, exp[N:0]);
    end
    vectors++;
    if (cnt_of(5) !== 16'd1) begin
      miscompares++;
      $display("FAIL dst_good_cnt: got %0d want 1", cnt_of(5));
    end
    do_clr();
  endtask

  task automatic test_bcast();
    set_pkt(0, mk_pkt(63));
    pndng[0] = 1'b1;
    pop[0] = 1'b1;
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd1);
    step();
    pndng = '0;
    pop = '0;
    exp = exp_q.pop_front();
    vectors++;
    if (b_dst_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL bcast_en1: got %h want %h", b_dst_err, exp[N-1:0]);
    end
    exp = exp_q.pop_front();
    vectors++;
    if (dst_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL bcast_en0: got %h want %h", dst_err, exp[N-1:0]);
    end
    do_clr();
  endtask

  task automatic test_simultaneous();
    logic [PW-1:0] q2;
    q2 = mk_pkt(2);
    set_pkt(2, q2);
    set_pkt(9, mk_pkt(4));
    pop[2] = 1'b1;
    pndng[9] = 1'b1;
    pop[9] = 1'b1;
    exp_q.push_back(64'(1) << 2);
    exp_q.push_back(64'(1) << 9);
    step();
    pndng = '0;
    pop = '0;
    exp = exp_q.pop_front();
    vectors++;
    if (proto_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL simul_proto: got %h want %h", proto_err, exp[N-1:0]);
    end
    exp = exp_q.pop_front();
    vectors++;
    if (dst_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL simul_dst: got %h want %h", dst_err, exp[N-1:0]);
    end
    vectors++;
    if ({err_any, first_err_vld, first_err_term, first_err_code, first_err_data} !== {2'b11, 4'd2, 2'd2, q2}) begin
      miscompares++;
      $display("FAIL simul_capture: got %h want %h", {err_any, first_err_vld, first_err_term, first_err_code, first_err_data}, {2'b11, 4'd2, 2'd2, q2});
    end
    do_clr();
  endtask

  task automatic test_stab_clr();
    logic [PW-1:0] a, b;
    a = mk_pkt(1);
    b = a;
    b[0] = ~b[0];
    set_pkt(1, a);
    pndng[1] = 1'b1;
    step();
    set_pkt(1, b);
    exp_q.push_back(64'(1) << 1);
    step();
    exp = exp_q.pop_front();
    vectors++;
    if (stab_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL stab_flag: got %h want %h", stab_err, exp[N-1:0]);
    end
    vectors++;
    if ({first_err_term, first_err_code, first_err_data} !== {4'd1, 2'd3, b}) begin
      miscompares++;
      $display("FAIL stab_capture: got %h want %h", {first_err_term, first_err_code, first_err_data}, {4'd1, 2'd3, b});
    end
    pop[1] = 1'b1;
    step();
    vectors++;
    if (cnt_of(1) !== 16'd1) begin
      miscompares++;
      $display("FAIL stab_cnt: got %0d want 1", cnt_of(1));
    end
    exp_q.push_back('0);
    do_clr();
    exp = exp_q.pop_front();
    vectors++;
    if ({timeout_err, dst_err, proto_err, stab_err, err_any, first_err_vld, |pkt_cnt, first_err_data} !== exp[N*4+42:0]) begin
      miscompares++;
      $display("FAIL clr_all: got %h want 0", {timeout_err, dst_err, proto_err, stab_err, err_any, first_err_vld, |pkt_cnt, first_err_data});
    end
    // error detected in the clearing cycle is kept
    clr = 1'b1;
    pop[6] = 1'b1;
    exp_q.push_back(64'(1) << 6);
    step();
    clr = 1'b0;
    pop = '0;
    exp = exp_q.pop_front();
    vectors++;
    if (proto_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL clr_err_wins: got %h want %h", proto_err, exp[N-1:0]);
    end
    vectors++;
    if ({first_err_vld, first_err_term, first_err_code} !== {1'b1, 4'd6, 2'd2}) begin
      miscompares++;
      $display("FAIL clr_err_capture: got %h want %h", {first_err_vld, first_err_term, first_err_code}, {1'b1, 4'd6, 2'd2});
    end
    do_clr();
  endtask

  task automatic test_reset_mid_wait();
    set_pkt(3, mk_pkt(3));
    pndng[3] = 1'b1;
    pop[0] = 1'b1;
    step();
    pop[0] = 1'b0;
    repeat (99) step();
    vectors++;
    if ({proto_err[0], timeout_err[3]} !== 2'b10) begin
      miscompares++;
      $display("FAIL midwait_pre: got %b want 10", {proto_err[0], timeout_err[3]});
    end
    reset = 1'b0;
    #2;
    exp_q.push_back('0);
    exp = exp_q.pop_front();
    vectors++;
    if ({proto_err, err_any, first_err_vld} !== exp[N+1:0]) begin
      miscompares++;
      $display("FAIL midwait_async: got %h want %h", {proto_err, err_any, first_err_vld}, exp[N+1:0]);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.push_back('0);
    repeat (127) step();
    exp = exp_q.pop_front();
    vectors++;
    if (timeout_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL midwait_127: got %h want %h", timeout_err, exp[N-1:0]);
    end
    exp_q.push_back(64'(1) << 3);
    step();
    exp = exp_q.pop_front();
    vectors++;
    if (timeout_err !== exp[N-1:0]) begin
      miscompares++;
      $display("FAIL midwait_128: got %h want %h", timeout_err, exp[N-1:0]);
    end
    vectors++;
    if ({first_err_term, first_err_code} !== {4'd3, 2'd1}) begin
      miscompares++;
      $display("FAIL midwait_capture: got %h want %h", {first_err_term, first_err_code}, {4'd3, 2'd1});
    end
    do_clr();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]  exp_dst, mask;
    int            exp_cnt[N];
    logic          exp_vld;
    logic [3:0]    exp_term;
    logic [PW-1:0] exp_data, p;
    logic          bad, x;
    exp_dst = '0;
    exp_vld = 1'b0;
    exp_term = '0;
    exp_data = '0;
    for (int t = 0; t < N; t++) exp_cnt[t] = 0;
    for (int c = 0; c < 60; c++) begin
      mask = '0;
      for (int t = 0; t < N; t++) begin
        x = 1'($urandom_range(0, 1));
        bad = ($urandom_range(0, 7) == 0);
        p = mk_pkt(bad ? (t ^ 1) : t);
        set_pkt(t, p);
        pndng[t] = x;
        pop[t] = x;
        if (x) exp_cnt[t]++;
        if (x && bad) begin
          if (!exp_vld && (mask == '0)) begin
            exp_term = 4'(t);
            exp_data = p;
          end
          mask[t] = 1'b1;
        end
      end
      if (mask != '0) exp_vld = 1'b1;
      exp_dst = exp_dst | mask;
      exp_q.push_back(W'(exp_dst));
      step();
      exp = exp_q.pop_front();
      vectors++;
      if (dst_err !== exp[N-1:0]) begin
        miscompares++;
        $display("FAIL b2b_dst cycle %0d: got %h want %h", c, dst_err, exp[N-1:0]);
      end
    end
    pndng = '0;
    pop = '0;
    for (int t = 0; t < N; t++) begin
      vectors++;
      if (cnt_of(t) !== CW'(exp_cnt[t])) begin
        miscompares++;
        $display("FAIL b2b_cnt term %0d: got %0d want %0d", t, cnt_of(t), exp_cnt[t]);
      end
    end
    vectors++;
    if (first_err_vld !== exp_vld ||
        (exp_vld && ({first_err_term, first_err_code, first_err_data} !== {exp_term, 2'd0, exp_data}))) begin
      miscompares++;
      $display("FAIL b2b_capture: got %b %h want %b %h", first_err_vld, {first_err_term, first_err_code, first_err_data}, exp_vld, {exp_term, 2'd0, exp_data});
    end
    do_clr();
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_dst();
    test_bcast();
    test_simultaneous();
    test_stab_clr();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
